// File: rtl/medida_serial_frame.sv
// ASCII frame sender: snapshots multi-channel BCD readings and streams them as
// characters to a 7E1 serial transmitter, with auto-periodic frames, timeout and overrun.
`timescale 1ns/1ps
module medida_serial_frame #(
  parameter int unsigned DIGITS     = 3,
  parameter int unsigned CHANNELS   = 2,
  parameter logic [6:0]  SEPARATOR  = 7'h2C,
  parameter logic [6:0]  TERMINATOR = 7'h23,
  parameter int unsigned PERIOD     = 50_000_000,
  parameter int unsigned TIMEOUT    = 1_000_000
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         enable,
  input  logic                         auto_mode,
  input  logic                         start,
  input  logic [4*DIGITS*CHANNELS-1:0] medidas,
  input  logic                         tx_pronto,
  output logic                         tx_partida,
  output logic [6:0]                   tx_dados,
  output logic                         busy,
  output logic                         frame_done,
  output logic                         erro,
  output logic                         overrun,
  output logic                         tick,
  output logic [3:0]                   db_estado
);

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_LATCH = 4'd1;
  localparam logic [3:0] S_SEND  = 4'd2;
  localparam logic [3:0] S_WAIT  = 4'd3;
  localparam logic [3:0] S_NEXT  = 4'd4;
  localparam logic [3:0] S_DONE  = 4'd5;
  localparam logic [3:0] S_ABORT = 4'd6;

  localparam int unsigned PW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int unsigned DW = $clog2(DIGITS + 1);

  localparam logic [PW-1:0] P_LAST  = PW'(PERIOD - 1);
  localparam logic [TW-1:0] W_LAST  = TW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CH_LAST = CW'(CHANNELS - 1);
  localparam logic [DW-1:0] POS_SEP = DW'(DIGITS);

  logic [3:0]                   r_state;
  logic [PW-1:0]                r_per_cnt;
  logic [TW-1:0]                r_wait;
  logic [CW-1:0]                r_ch;
  logic [DW-1:0]                r_pos;
  logic [4*DIGITS*CHANNELS-1:0] r_med;
  logic                         r_overrun;

  logic       w_tick;
  logic       w_req;
  logic       w_busy;
  logic       w_last;
  logic [3:0] w_digit;
  logic [6:0] w_char;

  assign w_tick = (r_per_cnt == P_LAST);
  assign w_req  = (start | (auto_mode & w_tick)) & enable;
  assign w_busy = (r_state >= S_LATCH) && (r_state <= S_DONE);
  assign w_last = (r_pos == POS_SEP) && (r_ch == CH_LAST);

  always_ff @(posedge clock) begin
    if (reset || !enable || w_tick) r_per_cnt <= '0;
    else                            r_per_cnt <= r_per_cnt + 1'b1;
  end

  // Current digit of the snapshot, selected by (channel, position); MS digit first.
  always_comb begin
    w_digit = '0;
    for (int unsigned c = 0; c < CHANNELS; c++)
      for (int unsigned d = 0; d < DIGITS; d++)
        if (32'(r_ch) == c && 32'(r_pos) == d)
          w_digit = r_med[4*DIGITS*c + 4*(DIGITS-1-d) +: 4];
  end

  always_comb begin
    w_char = 7'h3F;
    if (r_pos == POS_SEP)       w_char = (r_ch == CH_LAST) ? TERMINATOR : SEPARATOR;
    else if (w_digit <= 4'd9)   w_char = 7'h30 + {3'b000, w_digit};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_wait    <= '0;
      r_ch      <= '0;
      r_pos     <= '0;
      r_med     <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (auto_mode && w_tick && w_busy)                r_overrun <= 1'b1;
      else if (r_state == S_IDLE && start && enable)    r_overrun <= 1'b0;

      case (r_state)
        S_IDLE:  if (w_req) r_state <= S_LATCH;
        S_LATCH: begin
          r_med   <= medidas;
          r_ch    <= '0;
          r_pos   <= '0;
          r_state <= S_SEND;
        end
        S_SEND: begin
          r_wait  <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (tx_pronto)             r_state <= S_NEXT;
          else if (r_wait == W_LAST) r_state <= S_ABORT;
          else                       r_wait  <= r_wait + 1'b1;
        end
        S_NEXT: begin
          if (w_last) r_state <= S_DONE;
          else begin
            if (r_pos == POS_SEP) begin
              r_pos <= '0;
              r_ch  <= r_ch + 1'b1;
            end else begin
              r_pos <= r_pos + 1'b1;
            end
            r_state <= S_SEND;
          end
        end
        S_DONE, S_ABORT: r_state <= S_IDLE;
        default:         r_state <= S_IDLE;
      endcase
    end
  end

  // Character index only moves in NEXT, so tx_dados holds from partida until pronto.
  assign tx_dados   = (r_state == S_SEND || r_state == S_WAIT || r_state == S_NEXT) ? w_char : '0;
  assign tx_partida = (r_state == S_SEND);
  assign busy       = w_busy;
  assign frame_done = (r_state == S_DONE);
  assign erro       = (r_state == S_ABORT);
  assign overrun    = r_overrun;
  assign tick       = w_tick;
  assign db_estado  = r_state;

endmodule

// File: tb/tb_medida_serial_frame.sv
// Directed bench for medida_serial_frame: small PERIOD/TIMEOUT, behavioural tx_serial
// responder recording every character sent.
`timescale 1ns/1ps
module tb_medida_serial_frame;

  logic        clock = 1'b0;
  logic        reset, enable, auto_mode, start, tx_pronto;
  logic [23:0] medidas;
  logic        tx_partida, busy, frame_done, erro, overrun, tick;
  logic [6:0]  tx_dados;
  logic [3:0]  db_estado;

  int          n_vec = 0;
  int          n_err = 0;
  int          cnt_done = 0;
  int          cnt_erro = 0;
  bit          ack_en;
  int          ack_dly;
  logic [6:0]  chars[$];

  logic [6:0] exp_a [8] = '{7'h30, 7'h34, 7'h35, 7'h2C, 7'h31, 7'h32, 7'h33, 7'h23};
  logic [6:0] exp_b [8] = '{7'h30, 7'h3F, 7'h35, 7'h2C, 7'h31, 7'h32, 7'h33, 7'h23};

  medida_serial_frame #(
    .DIGITS(3), .CHANNELS(2), .SEPARATOR(7'h2C), .TERMINATOR(7'h23),
    .PERIOD(100), .TIMEOUT(50)
  ) u_dut (
    .clock(clock), .reset(reset), .enable(enable), .auto_mode(auto_mode),
    .start(start), .medidas(medidas), .tx_pronto(tx_pronto),
    .tx_partida(tx_partida), .tx_dados(tx_dados), .busy(busy),
    .frame_done(frame_done), .erro(erro), .overrun(overrun), .tick(tick),
    .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (frame_done) cnt_done++;
    if (erro)       cnt_erro++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Serial transmitter stand-in: records the char at partida, acks ack_dly cycles later.
  initial begin
    tx_pronto = 1'b0;
    forever begin
      @(negedge clock);
      if (tx_partida) begin
        chars.push_back(tx_dados);
        if (ack_en) begin
          repeat (ack_dly) @(negedge clock);
          tx_pronto = 1'b1;
          @(negedge clock);
          tx_pronto = 1'b0;
        end
      end
    end
  end

  task automatic pulse_start;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_end(input string tag, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clock);
      seen = frame_done | erro;
    end
    check({tag, "_end"}, 32'(seen), 32'd1);
  endtask

  task automatic wait_tick(input string tag, input int budget, output int n);
    bit seen = 1'b0;
    n = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clock);
      n++;
      seen = tick;
    end
    check({tag, "_tick"}, 32'(seen), 32'd1);
  endtask

  task automatic check_frame(input string tag, input logic [6:0] exp [8]);
    check({tag, "_len"}, 32'(chars.size()), 32'd8);
    for (int i = 0; i < 8; i++)
      if (i < chars.size()) check($sformatf("%s_c%0d", tag, i), 32'(chars[i]), 32'(exp[i]));
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_partida"}, 32'(tx_partida), 32'd0);
    check({tag, "_dados"},   32'(tx_dados),   32'd0);
    check({tag, "_busy"},    32'(busy),       32'd0);
    check({tag, "_done"},    32'(frame_done), 32'd0);
    check({tag, "_erro"},    32'(erro),       32'd0);
    check({tag, "_overrun"}, 32'(overrun),    32'd0);
    check({tag, "_tick"},    32'(tick),       32'd0);
    check({tag, "_estado"},  32'(db_estado),  32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, base;
    bit seen;
    reset = 1'b1; enable = 1'b0; auto_mode = 1'b0; start = 1'b0;
    medidas = '0; ack_en = 1'b1; ack_dly = 10;
    repeat (3) @(negedge clock);
    check_idle_zero("rst");

    // Frame 1: latency, snapshot isolation, character order
    reset = 1'b0; enable = 1'b1; medidas = 24'h123045;
    chars.delete();
    @(negedge clock);
    base = cnt_done;
    pulse_start();
    check("lat_latch", 32'(db_estado), 32'd1);
    check("lat_busy", 32'(busy), 32'd1);
    check("lat_nopart", 32'(tx_partida), 32'd0);
    @(negedge clock);
    check("lat_send", 32'(tx_partida), 32'd1);
    check("lat_dados", 32'(tx_dados), 32'h30);
    medidas = 24'h999999;
    wait_end("f1", 400);
    check("f1_done", 32'(frame_done), 32'd1);
    @(negedge clock);
    check("f1_pulse", 32'(frame_done), 32'd0);
    check("f1_busy", 32'(busy), 32'd0);
    check("f1_count", 32'(cnt_done - base), 32'd1);
    check_frame("f1", exp_a);

    // Non-decimal digit maps to '?'
    medidas = {12'h123, 12'h0A5};
    chars.delete();
    pulse_start();
    wait_end("f3", 400);
    @(negedge clock);
    check_frame("f3", exp_b);

    // Timeout: no ack ever
    ack_en = 1'b0;
    chars.delete();
    base = cnt_erro;
    pulse_start();
    @(negedge clock);
    check("to_send", 32'(tx_partida), 32'd1);
    n = 0; seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clock);
      n++;
      seen = erro;
    end
    check("to_latency", 32'(n), 32'd51);
    check("to_abort", 32'(db_estado), 32'd6);
    @(negedge clock);
    check("to_erro_pulse", 32'(erro), 32'd0);
    check("to_idle", 32'(db_estado), 32'd0);
    check("to_nchars", 32'(chars.size()), 32'd1);
    check("to_count", 32'(cnt_erro - base), 32'd1);

    // Reset while waiting for pronto
    pulse_start();
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clock);
      seen = (db_estado == 4'd3);
    end
    check("rw_inwait", 32'(seen), 32'd1);
    reset = 1'b1;
    @(negedge clock);
    check_idle_zero("rw");
    reset = 1'b0; medidas = 24'h123045;
    chars.delete(); ack_en = 1'b1; ack_dly = 3;
    pulse_start();
    wait_end("rw_f", 400);
    check("rw_f_done", 32'(frame_done), 32'd1);
    @(negedge clock);
    check_frame("rw_f", exp_a);

    // Period generator and auto mode with overrun
    wait_tick("per0", 150, n);
    wait_tick("per1", 150, n);
    check("tick_period", 32'(n), 32'd100);
    @(negedge clock);
    check("tick_pulse", 32'(tick), 32'd0);
    ack_dly = 20; chars.delete(); auto_mode = 1'b1;
    wait_tick("au0", 150, n);
    check("au0_idle", 32'(db_estado), 32'd0);
    @(negedge clock);
    check("au0_latch", 32'(db_estado), 32'd1);
    wait_end("au0", 400);
    check("au0_ovr", 32'(overrun), 32'd1);
    check_frame("au0", exp_a);
    wait_tick("au1", 150, n);
    check("au1_idle", 32'(db_estado), 32'd0);
    @(negedge clock);
    check("au1_latch", 32'(db_estado), 32'd1);
    auto_mode = 1'b0;
    wait_end("au1", 400);
    @(negedge clock);
    check("ovr_sticky", 32'(overrun), 32'd1);
    pulse_start();
    check("ovr_clear", 32'(overrun), 32'd0);
    check("ovr_latch", 32'(db_estado), 32'd1);

    // enable dropped mid-frame: frame completes, nothing new starts
    enable = 1'b0;
    wait_end("en", 400);
    check("en_done", 32'(frame_done), 32'd1);
    start = 1'b1;
    repeat (5) @(negedge clock);
    check("en_idle", 32'(db_estado), 32'd0);
    check("en_notick", 32'(tick), 32'd0);
    start = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
